// File: rtl/mc_controller_v2_if.sv
// mc_controller_v2_if: IR/flag inputs, data memory handshake and datapath control strobes
interface mc_controller_v2_if #(parameter int IW = 32);
    logic [IW-1:0] ir;
    logic          ir_valid;
    logic [3:0]    nzcv;
    logic          mem_ack;
    logic          write_pc, write_ir, write_reg;
    logic          LA, LB, LC, LF;
    logic [1:0]    pc_s;
    logic          ALU_A_s, ALU_B_s, rd_s;
    logic          mem_req, mem_we;
    logic          und_ins, mem_err, busy;
    logic [2:0]    state;
    modport master (
        input  ir, ir_valid, nzcv, mem_ack,
        output write_pc, write_ir, write_reg, LA, LB, LC, LF, pc_s, ALU_A_s, ALU_B_s, rd_s,
               mem_req, mem_we, und_ins, mem_err, busy, state
    );
    modport slave (
        output ir, ir_valid, nzcv, mem_ack,
        input  write_pc, write_ir, write_reg, LA, LB, LC, LF, pc_s, ALU_A_s, ALU_B_s, rd_s,
               mem_req, mem_we, und_ins, mem_err, busy, state
    );
endinterface

// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multi-cycle CPU controller with ARM condition gating, branch and load/store sequencing
module mc_controller_v2 #(
    parameter int IW          = 32,
    parameter int HAS_MEM     = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input logic clk,
    input logic rst,
    mc_controller_v2_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        MEM    = 3'd4,
        MEMWB  = 3'd5,
        BRANCH = 3'd6
    } state_t;
    if (IW < 32 || (1 << TW) <= MEM_TIMEOUT) begin : g_bad_params
        $error("mc_controller_v2: need IW >= 32 and 2**TW > MEM_TIMEOUT");
    end
    state_t        st;
    logic [TW-1:0] cnt;
    logic          und_q, err_q;
    logic [3:0]    cond;
    logic [2:0]    cls;
    logic          n, z, c, v, cond_ok, is_ls, is_bl, is_load, cls_ok;
    assign cond    = bus.ir[31:28];
    assign cls     = bus.ir[27:25];
    assign is_bl   = bus.ir[24];
    assign is_load = bus.ir[20];
    assign {n, z, c, v} = bus.nzcv;
    assign is_ls   = cls == 3'b010;
    assign cls_ok  = cls == 3'b000 || cls == 3'b001 || (HAS_MEM != 0 && is_ls);
    always_comb
        case (cond)
            4'h0:    cond_ok = z;
            4'h1:    cond_ok = !z;
            4'h2:    cond_ok = c;
            4'h3:    cond_ok = !c;
            4'h4:    cond_ok = n;
            4'h5:    cond_ok = !n;
            4'h6:    cond_ok = v;
            4'h7:    cond_ok = !v;
            4'h8:    cond_ok = c && !z;
            4'h9:    cond_ok = !c || z;
            4'hA:    cond_ok = n == v;
            4'hB:    cond_ok = n != v;
            4'hC:    cond_ok = !z && n == v;
            4'hD:    cond_ok = z || n != v;
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    always_ff @(posedge clk)
        if (!rst) begin
            st    <= FETCH;
            cnt   <= '0;
            und_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            und_q <= 1'b0;
            err_q <= 1'b0;
            case (st)
                FETCH:  if (bus.ir_valid) st <= DECODE;
                DECODE:
                    if (cond == 4'hF) begin
                        und_q <= 1'b1;
                        st    <= FETCH;
                    end else if (!cond_ok)
                        st <= FETCH;
                    else if (cls == 3'b101)
                        st <= BRANCH;
                    else if (cls_ok)
                        st <= EXEC;
                    else begin
                        und_q <= 1'b1;
                        st    <= FETCH;
                    end
                EXEC:   st <= is_ls ? MEM : (bus.ir[24:23] == 2'b10 ? FETCH : WB);
                // ack wins over timeout, even on the last allowed cycle
                MEM:
                    if (bus.mem_ack) begin
                        cnt <= '0;
                        st  <= is_load ? MEMWB : FETCH;
                    end else if (cnt == TW'(MEM_TIMEOUT)) begin
                        cnt   <= '0;
                        err_q <= 1'b1;
                        st    <= FETCH;
                    end else
                        cnt <= cnt + TW'(1);
                default: st <= FETCH;
            endcase
        end
    assign bus.write_ir  = st == FETCH && bus.ir_valid;
    assign bus.write_pc  = (st == FETCH && bus.ir_valid) || st == BRANCH;
    assign bus.write_reg = st == WB || st == MEMWB || (st == BRANCH && is_bl);
    assign bus.LA        = st == DECODE;
    assign bus.LB        = st == DECODE;
    assign bus.LC        = st == EXEC;
    assign bus.LF        = st == EXEC && !is_ls && is_load;
    assign bus.pc_s      = st == BRANCH ? 2'b01 : 2'b00;
    assign bus.ALU_A_s   = st == BRANCH;
    assign bus.ALU_B_s   = st == BRANCH || (st == EXEC && is_ls);
    assign bus.rd_s      = st == BRANCH && is_bl;
    assign bus.mem_req   = st == MEM;
    assign bus.mem_we    = st == MEM && !is_load;
    assign bus.und_ins   = und_q;
    assign bus.mem_err   = err_q;
    assign bus.busy      = st != FETCH;
    assign bus.state     = st;
endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: directed and random instructions checked cycle by cycle against a path-level model
module tb_mc_controller_v2;
    localparam int MT = 15;
    typedef struct {
        logic [19:0] exp;
        bit          iv;
        bit          ack;
    } tr_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    tr_t  tq[$];
    mc_controller_v2_if #(.IW(32)) bus ();
    mc_controller_v2 #(.IW(32), .HAS_MEM(1), .MEM_TIMEOUT(MT), .TW(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    function automatic logic [19:0] observed();
        return {bus.state, bus.busy, bus.write_pc, bus.write_ir, bus.write_reg, bus.LA, bus.LB,
                bus.LC, bus.LF, bus.pc_s, bus.ALU_A_s, bus.ALU_B_s, bus.rd_s, bus.mem_req,
                bus.mem_we, bus.und_ins, bus.mem_err};
    endfunction

    // ARM rule: even codes test a base predicate, odd codes its inverse (AL is 1110)
    function automatic bit cond_pass(input logic [3:0] cd, input logic [3:0] f);
        bit nf = f[3], zf = f[2], cf = f[1], vf = f[0], base;
        case (cd[3:1])
            3'd0:    base = zf;
            3'd1:    base = cf;
            3'd2:    base = nf;
            3'd3:    base = vf;
            3'd4:    base = cf && !zf;
            3'd5:    base = nf == vf;
            3'd6:    base = !zf && nf == vf;
            default: base = 1'b1;
        endcase
        return cd[0] ? !base : base;
    endfunction

    function automatic logic [19:0] expv(input int s, input logic [31:0] w, input bit fv,
                                         input bit u, input bit e);
        bit ls = w[27:25] == 3'b010;
        bit bl = w[24];
        return {3'(s), s != 0, (s == 0 && fv) || s == 6, s == 0 && fv,
                s == 3 || s == 5 || (s == 6 && bl), s == 1, s == 1, s == 2,
                s == 2 && !ls && w[20], (s == 6) ? 2'b01 : 2'b00, s == 6,
                s == 6 || (s == 2 && ls), s == 6 && bl, s == 4, s == 4 && !w[20], u, e};
    endfunction

    // Expected state path plus one trailing idle FETCH cycle that carries the und/err pulse
    function automatic void build(input logic [31:0] w, input logic [3:0] f, input int ack_at);
        int  path[$];
        int  cls = int'(w[27:25]);
        bit  u = 0, e = 0;
        int  mp = 0;
        tr_t t;
        tq.delete();
        path = '{0, 1};
        if (w[31:28] == 4'hF) u = 1;
        else if (cond_pass(w[31:28], f)) begin
            if (cls == 5) path.push_back(6);
            else if (cls <= 2) begin
                path.push_back(2);
                if (cls == 2) begin
                    int m = (ack_at >= 1 && ack_at <= MT + 1) ? ack_at : MT + 1;
                    repeat (m) path.push_back(4);
                    if (m == ack_at) begin
                        if (w[20]) path.push_back(5);
                    end else e = 1;
                end else if (w[24:23] != 2'b10) path.push_back(3);
            end else u = 1;
        end
        path.push_back(0);
        foreach (path[k]) begin
            bit last = k == path.size() - 1;
            if (path[k] == 4) mp++;
            t.iv  = k == 0;
            t.ack = path[k] == 4 && mp == ack_at;
            t.exp = expv(path[k], w, t.iv, last && u, last && e);
            tq.push_back(t);
        end
    endfunction

    task automatic check(input logic [19:0] exp, input string tag, input int k);
        logic [19:0] obs = observed();
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic [3:0] f, input tr_t t);
        @(negedge clk);
        bus.ir       = w;
        bus.nzcv     = f;
        bus.ir_valid = t.iv;
        bus.mem_ack  = t.ack;
        #1;
    endtask

    task automatic run(input logic [31:0] w, input logic [3:0] f, input int ack_at,
                       input string tag);
        build(w, f, ack_at);
        foreach (tq[k]) begin
            drive(w, f, tq[k]);
            check(tq[k].exp, tag, k);
        end
    endtask

    initial begin
        tr_t idle;
        idle = '{exp: '0, iv: 1'b0, ack: 1'b0};
        bus.ir = '0;
        bus.nzcv = '0;
        bus.ir_valid = 1'b0;
        bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        drive(32'h0, 4'h0, idle);
        check(20'h0, "reset", 0);
        rst = 1'b1;
        run(32'hE0812003, 4'h0, 0, "add");
        run(32'h03A01001, 4'h0, 0, "moveq_fail");
        run(32'h03A01001, 4'h4, 0, "moveq_pass");
        run(32'hE1500001, 4'h0, 0, "cmp");
        run(32'hE0912003, 4'h0, 0, "adds");
        run(32'hE5912000, 4'h0, 3, "ldr_ack3");
        run(32'hE5912000, 4'h0, 1, "ldr_ack1");
        // reset while waiting in MEM: request must drop and counter must restart
        build(32'hE5912000, 4'h0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(32'hE5912000, 4'h0, tq[k]);
            check(tq[k].exp, "ldr_pre_rst", k);
        end
        rst = 1'b0;
        drive(32'hE5912000, 4'h0, idle);
        check(20'h0, "mid_mem_rst", 0);
        rst = 1'b1;
        drive(32'hE5912000, 4'h0, idle);
        check(20'h0, "post_rst_idle", 0);
        run(32'hE5812000, 4'h0, 0, "str_timeout");
        run(32'hE5812000, 4'h0, 16, "str_ack_last");
        run(32'hE5812000, 4'h0, 17, "str_ack_late");
        run(32'hEB000010, 4'h0, 0, "bl");
        run(32'hEA000010, 4'h0, 0, "b");
        run(32'hF0812003, 4'h0, 0, "cond_nv");
        run(32'hE6000000, 4'h0, 0, "class_011");
        run(32'hEE000000, 4'h0, 0, "class_111");
        for (int i = 0; i < 300; i++) begin
            logic [31:0] w = $urandom;
            if ($urandom_range(0, 3) != 0) w[31:28] = 4'hE;
            if ($urandom_range(0, 2) == 0) w[27:25] = 3'b010;
            run(w, 4'($urandom), int'($urandom_range(0, 18)), $sformatf("rand%0d", i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
